// File: rtl/smpl_circuit_seq_ctrl_if.sv
// Bus between the self-test sequencer and its environment:
// start request, circuit-under-test outputs, stimulus vector and sweep results.
interface smpl_circuit_seq_ctrl_if;
  logic       start;
  logic       x_in;
  logic       y_in;
  logic [2:0] abc;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_vec;
  logic [3:0] err_cnt;

  modport master (
    input  start, x_in, y_in,
    output abc, busy, done, pass, fail_vec, err_cnt
  );

  modport slave (
    output start, x_in, y_in,
    input  abc, busy, done, pass, fail_vec, err_cnt
  );
endinterface

// File: rtl/smpl_circuit_seq_ctrl.sv
// Self-test sequencer: sweeps {A,B,C} through 0..7, lets each vector settle,
// samples x/y once per vector and accumulates a fail map against a golden table.
module smpl_circuit_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  EXP_X      = 8'hD5,
  parameter logic [7:0]  EXP_Y      = 8'h55
) (
  input  logic                          clk,
  input  logic                          rst_n,
  smpl_circuit_seq_ctrl_if.master       bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] fail_q, fail_d;
  logic [3:0] err_q, err_d;

  logic       mismatch;
  logic [7:0] fail_upd;

  // One mismatch per vector regardless of whether x, y or both are wrong.
  assign mismatch = (bus.x_in != EXP_X[idx_q]) || (bus.y_in != EXP_Y[idx_q]);
  assign fail_upd = fail_q | (mismatch ? (8'd1 << idx_q) : 8'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          abc_d   = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 8'd0;
          err_d   = 4'd0;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        fail_d = fail_upd;
        if (mismatch) begin
          err_d = err_q + 4'd1;
        end
        if (idx_q == 3'd7) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_upd == 8'd0);
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          cnt_d   = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 8'd0;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign bus.abc      = abc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_vec = fail_q;
  assign bus.err_cnt  = err_q;

endmodule

// File: tb/tb_smpl_circuit_seq_ctrl.sv
// Scoreboard bench for the smpl_circuit self-test sequencer with a fault-injectable
// circuit model and a truth-table reference computed from the boolean equations.
module tb_smpl_circuit_seq_ctrl;

  localparam int S    = 2;
  localparam int SPAN = 8 * (S + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smpl_circuit_seq_ctrl_if bus ();

  smpl_circuit_seq_ctrl #(.SETTLE_CYC(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Fault configuration of the modelled circuit under test
  logic       sx_en = 1'b0, sx_val = 1'b0;
  logic       sy_en = 1'b0, sy_val = 1'b0;
  logic [7:0] fx = 8'd0, fy = 8'd0;

  function automatic logic gold_x(input logic [2:0] v);
    return (v[2] & v[1]) | ~v[0];
  endfunction

  function automatic logic gold_y(input logic [2:0] v);
    return ~v[0];
  endfunction

  always_comb begin
    bus.x_in = sx_en ? sx_val : (gold_x(bus.abc) ^ fx[bus.abc]);
    bus.y_in = sy_en ? sy_val : (gold_y(bus.abc) ^ fy[bus.abc]);
  end

  typedef struct {
    int         start_edge;
    logic [7:0] fv;
    logic [3:0] ec;
    logic       ps;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input int start_edge);
    exp_t e;
    e.start_edge = start_edge;
    e.fv = 8'd0;
    e.ec = 4'd0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] a;
      logic ax, ay;
      a  = 3'(v);
      ax = sx_en ? sx_val : (gold_x(a) ^ fx[v]);
      ay = sy_en ? sy_val : (gold_y(a) ^ fy[v]);
      if (ax != gold_x(a) || ay != gold_y(a)) begin
        e.fv[v] = 1'b1;
        e.ec    = e.ec + 4'd1;
      end
    end
    e.ps = (e.fv == 8'd0);
    return e;
  endfunction

  // Monitor: checks the in-flight sweep every cycle and the results at completion
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      int t;
      t = cyc - sb[0].start_edge;
      if (t >= 0 && t < SPAN) begin
        chk("busy", 32'(bus.busy), 32'd1);
        chk("done_low", 32'(bus.done), 32'd0);
        chk("abc", 32'(bus.abc), 32'(t / (S + 1)));
        if (t == 0) begin
          chk("fail_vec_clr", 32'(bus.fail_vec), 32'd0);
          chk("err_cnt_clr", 32'(bus.err_cnt), 32'd0);
        end
      end else if (t == SPAN) begin
        chk("done", 32'(bus.done), 32'd1);
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("abc_end", 32'(bus.abc), 32'd7);
        chk("fail_vec", 32'(bus.fail_vec), 32'(sb[0].fv));
        chk("err_cnt", 32'(bus.err_cnt), 32'(sb[0].ec));
        chk("pass", 32'(bus.pass), 32'(sb[0].ps));
        void'(sb.pop_front());
      end
    end
  end

  task automatic issue_start(input bit accept);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    if (accept) sb.push_back(ref_model(cyc + 1));
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * SPAN) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got pending=%0d expected pending=0 at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_abc"},  32'(bus.abc), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_fail"}, 32'(bus.fail_vec), 32'd0);
    chk({tag, "_err"},  32'(bus.err_cnt), 32'd0);
  endtask

  task automatic clear_faults();
    sx_en = 1'b0; sy_en = 1'b0; sx_val = 1'b0; sy_val = 1'b0;
    fx = 8'd0; fy = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Golden circuit
    clear_faults();
    issue_start(1'b1);
    wait_done();
    chk("golden_pass", 32'(bus.pass), 32'd1);

    // x stuck-at-0, then y stuck-at-1
    sx_en = 1'b1; sx_val = 1'b0;
    issue_start(1'b1);
    wait_done();
    chk("xs0_fail_vec", 32'(bus.fail_vec), 32'hD5);
    chk("xs0_err_cnt", 32'(bus.err_cnt), 32'd5);
    clear_faults();
    sy_en = 1'b1; sy_val = 1'b1;
    issue_start(1'b1);
    wait_done();
    chk("ys1_fail_vec", 32'(bus.fail_vec), 32'hAA);
    chk("ys1_err_cnt", 32'(bus.err_cnt), 32'd4);

    // Both outputs wrong on vector 3 only; still a single count
    clear_faults();
    fx = 8'h08; fy = 8'h08;
    issue_start(1'b1);
    wait_done();
    chk("v3_fail_vec", 32'(bus.fail_vec), 32'h08);
    chk("v3_err_cnt", 32'(bus.err_cnt), 32'd1);

    // Start from DONE with failing results: clears, then a clean sweep passes
    clear_faults();
    issue_start(1'b1);
    wait_done();
    chk("rerun_pass", 32'(bus.pass), 32'd1);

    // Extra start pulses during vectors 2 and 5 are ignored
    issue_start(1'b1);
    repeat (5) @(posedge clk);
    issue_start(1'b0);
    repeat (7) @(posedge clk);
    issue_start(1'b0);
    wait_done();

    // Reset during vector 4 aborts the sweep with no partial results
    fx = 8'hFF;
    issue_start(1'b1);
    repeat (13) @(posedge clk);
    #2;
    chk("pre_reset_abc", 32'(bus.abc), 32'd4);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_all_zero("midreset");
    issue_start(1'b1);
    wait_done();

    // Randomized fault patterns, gaps and ignored mid-sweep starts
    for (int i = 0; i < 10; i++) begin
      clear_faults();
      fx = 8'($urandom);
      fy = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sx_en = 1'b1; sx_val = 1'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        sy_en = 1'b1; sy_val = 1'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        fx = 8'd0; fy = 8'd0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue_start(1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, SPAN - 6)) @(posedge clk);
        issue_start(1'b0);
      end
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
